mux_gate_scheduler: RTL and testbench



---
 rtl/mux_gate_pkg.sv | 80 ++++++++
 rtl/mux_2_1.sv | 15 +
 rtl/rr_arbiter.sv | 50 +++++
 rtl/mux_gate_scheduler.sv | 155 +++++++++++++++
 tb/tb_mux_gate_scheduler.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_gate_pkg.sv
// mux_gate_pkg: shared definitions for the mux-based gate scheduler.
//   - op code constants (OP_NOT .. OP_BUF)
//   - FSM state type
//   - mux source-select type and the (op, step) -> (sel, d1, d0) table
//   - helpers that classify ops and resolve a source to a bit
package mux_gate_pkg;

  localparam logic [2:0] OP_NOT  = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_BUF  = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    EXEC1,
    EXEC2,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    SRC_0,
    SRC_1,
    SRC_A,
    SRC_B,
    SRC_T
  } src_t;

  typedef struct packed {
    src_t sel;
    src_t d1;
    src_t d0;
  } step_cfg_t;

  // NAND/NOR/XOR/XNOR need ~b parked in the temp register first.
  function automatic logic is_two_step(input logic [2:0] op);
    return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XOR) || (op == OP_XNOR);
  endfunction

  // Mux wiring for each step: y = sel ? d1 : d0.
  function automatic step_cfg_t step_cfg(input logic [2:0] op, input logic second);
    step_cfg_t c;
    c = '{sel: SRC_A, d1: SRC_1, d0: SRC_0};
    if (!second) begin
      case (op)
        OP_NOT:  c = '{sel: SRC_A, d1: SRC_0, d0: SRC_1};
        OP_AND:  c = '{sel: SRC_A, d1: SRC_B, d0: SRC_0};
        OP_OR:   c = '{sel: SRC_A, d1: SRC_1, d0: SRC_B};
        OP_BUF:  c = '{sel: SRC_A, d1: SRC_1, d0: SRC_0};
        // every two-step op starts with t = ~b
        default: c = '{sel: SRC_B, d1: SRC_0, d0: SRC_1};
      endcase
    end else begin
      case (op)
        OP_NAND: c = '{sel: SRC_A, d1: SRC_T, d0: SRC_1};
        OP_NOR:  c = '{sel: SRC_A, d1: SRC_0, d0: SRC_T};
        OP_XOR:  c = '{sel: SRC_A, d1: SRC_T, d0: SRC_B};
        OP_XNOR: c = '{sel: SRC_A, d1: SRC_B, d0: SRC_T};
        default: c = '{sel: SRC_A, d1: SRC_1, d0: SRC_0};
      endcase
    end
    return c;
  endfunction

  function automatic logic src_value(input src_t s, input logic a, input logic b,
                                     input logic t);
    case (s)
      SRC_0:   return 1'b0;
      SRC_1:   return 1'b1;
      SRC_A:   return a;
      SRC_B:   return b;
      SRC_T:   return t;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mux_2_1.sv
// mux_2_1: the single shared 2:1 mux cell.
//   sel, d0, d1 : inputs
//   y           : sel ? d1 : d0
module mux_2_1 (
  input  logic sel,
  input  logic d0,
  input  logic d1,
  output logic y
);

  always_comb begin
    y = sel ? d1 : d0;
  end

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with an internal last-grant pointer.
//   clk, rst   : clock, synchronous active-high reset
//   req        : per-requester request
//   advance    : a grant is being taken this cycle; pointer moves to it
//   grant      : one-hot grant (zero when no request)
//   grant_idx  : index of the granted requester
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  localparam int unsigned N = NREQ;

  logic [IDW-1:0] last_g;
  logic           found;
  int unsigned    cand;

  // Search starts one past the last winner and wraps around.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = (32'(last_g) + k) % N;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDW'(cand);
      end
    end
  end

  // Reset to the top index so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_g <= IDW'(NREQ - 1);
    end else if (advance && found) begin
      last_g <= grant_idx;
    end
  end

endmodule

// File: rtl/mux_gate_scheduler.sv
// mux_gate_scheduler: time-shares one mux_2_1 among NREQ requesters, each
// asking for a 1-bit function of (a, b). One request is accepted at a time,
// evaluated in one or two mux steps, and presented on a valid/ready output.
//   clk, rst   : clock, synchronous active-high reset
//   req_valid  : per-requester request valid
//   req_ready  : per-requester accept (one-hot or zero, IDLE only)
//   req_a/b    : operand bits, bit i for requester i
//   req_op     : op codes, [3i+2:3i] for requester i
//   out_valid  : result valid (DONE state)
//   out_ready  : consumer accepts result
//   out_y      : result bit
//   out_id     : requester owning the result
//   busy       : FSM not idle
//   op_count   : completed results, wrapping
module mux_gate_scheduler
  import mux_gate_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ),
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_a,
  input  logic [NREQ-1:0]   req_b,
  input  logic [3*NREQ-1:0] req_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_y,
  output logic [IDW-1:0]    out_id,
  output logic              busy,
  output logic [CNTW-1:0]   op_count
);

  state_t         state, state_next;
  logic           a_q, b_q, t_q, y_q;
  logic [2:0]     op_q;
  logic [IDW-1:0] id_q;
  logic [CNTW-1:0] count_q;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            any_req;
  logic            accept;
  logic            ld_t, ld_y, retire;

  step_cfg_t cfg;
  logic      mux_sel, mux_d0, mux_d1, mux_y;

  assign any_req = |req_valid;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Source resolution only routes bits; the function itself comes from the mux.
  always_comb begin
    cfg     = step_cfg(op_q, state == EXEC2);
    mux_sel = src_value(cfg.sel, a_q, b_q, t_q);
    mux_d1  = src_value(cfg.d1,  a_q, b_q, t_q);
    mux_d0  = src_value(cfg.d0,  a_q, b_q, t_q);
  end

  mux_2_1 u_mux (
    .sel (mux_sel),
    .d0  (mux_d0),
    .d1  (mux_d1),
    .y   (mux_y)
  );

  always_comb begin
    state_next = state;
    req_ready  = '0;
    accept     = 1'b0;
    ld_t       = 1'b0;
    ld_y       = 1'b0;
    retire     = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          req_ready  = grant;
          accept     = 1'b1;
          state_next = EXEC1;
        end
      end
      EXEC1: begin
        if (is_two_step(op_q)) begin
          ld_t       = 1'b1;
          state_next = EXEC2;
        end else begin
          ld_y       = 1'b1;
          state_next = DONE;
        end
      end
      EXEC2: begin
        ld_y       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        if (out_ready) begin
          retire     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      op_q    <= '0;
      id_q    <= '0;
      t_q     <= 1'b0;
      y_q     <= 1'b0;
      count_q <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        a_q  <= req_a[grant_idx];
        b_q  <= req_b[grant_idx];
        op_q <= req_op[3*grant_idx +: 3];
        id_q <= grant_idx;
      end
      if (ld_t) begin
        t_q <= mux_y;
      end
      if (ld_y) begin
        y_q <= mux_y;
      end
      if (retire) begin
        count_q <= count_q + CNTW'(1);
      end
    end
  end

  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_y     = y_q;
  assign out_id    = id_q;
  assign op_count  = count_q;

endmodule

// File: tb/tb_mux_gate_scheduler.sv
module tb_mux_gate_scheduler;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int CNTW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_a;
  logic [NREQ-1:0]   req_b;
  logic [3*NREQ-1:0] req_op;
  logic              out_valid;
  logic              out_ready;
  logic              out_y;
  logic [IDW-1:0]    out_id;
  logic              busy;
  logic [CNTW-1:0]   op_count;

  int errors = 0;
  int checks = 0;
  int exp_count = 0;

  mux_gate_scheduler #(
    .NREQ (NREQ),
    .IDW  (IDW),
    .CNTW (CNTW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_id    (out_id),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Step into the low phase of the next cycle; drive and sample there.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic ref_fn(input logic [2:0] op, input logic a, input logic b);
    case (op)
      3'd0:    return ~a;
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return a ^ b;
      3'd6:    return ~(a ^ b);
      default: return a;
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
    exp_count = 0;
  endtask

  // One complete transaction on requester idx with out_ready held high.
  task automatic run_op(input int idx, input logic [2:0] op, input logic a, input logic b);
    int w;
    int lat;
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    req_a[idx] = a;
    req_b[idx] = b;
    req_op[3*idx +: 3] = op;
    req_valid = oh;
    #1;
    w = 0;
    while (!req_ready[idx] && w < 20) begin
      tick();
      w++;
    end
    check($sformatf("accept r%0d op%0d", idx, op), 32'(req_ready), 32'(oh));
    tick();
    req_valid = '0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check($sformatf("latency op%0d", op), lat, (op >= 3 && op <= 6) ? 3 : 2);
    check($sformatf("y op%0d a%0d b%0d", op, a, b), 32'(out_y), 32'(ref_fn(op, a, b)));
    check($sformatf("id op%0d", op), 32'(out_id), idx);
    tick();
    exp_count = (exp_count + 1) % 16;
    check("count", 32'(op_count), exp_count);
  endtask

  initial begin
    logic seen;
    int w;
    int lat;

    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    out_ready = 1'b1;
    tick();
    tick();

    // Reset state
    check("rst out_valid", 32'(out_valid), 0);
    check("rst busy", 32'(busy), 0);
    check("rst req_ready", 32'(req_ready), 0);
    check("rst op_count", 32'(op_count), 0);
    check("rst out_y", 32'(out_y), 0);
    check("rst out_id", 32'(out_id), 0);
    rst = 1'b0;

    // Reset mid-operation: NAND(0,0) would give 1, must never appear
    req_a[0] = 1'b0;
    req_b[0] = 1'b0;
    req_op[2:0] = 3'd3;
    req_valid = 4'b0001;
    #1;
    check("midrst accept", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    tick();
    check("midrst busy exec2", 32'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst out_valid", 32'(out_valid), 0);
    check("midrst busy", 32'(busy), 0);
    check("midrst op_count", 32'(op_count), 0);
    check("midrst out_y", 32'(out_y), 0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | out_valid | busy;
    end
    check("midrst no result", 32'(seen), 0);
    exp_count = 0;

    // Truth tables on requester 0
    for (int op = 0; op < 8; op++) begin
      for (int ab = 0; ab < 4; ab++) begin
        run_op(0, 3'(op), ab[1], ab[0]);
      end
    end

    // Round-robin with all requesters holding valid
    do_reset();
    req_a = '1;
    req_b = '1;
    for (int i = 0; i < NREQ; i++) req_op[3*i +: 3] = 3'd1;
    req_valid = '1;
    #1;
    for (int n = 0; n < 5; n++) begin
      w = 0;
      while (req_ready == '0 && w < 20) begin
        tick();
        w++;
      end
      check($sformatf("rr onehot %0d", n), 32'($onehot(req_ready)), 1);
      check($sformatf("rr grant %0d", n), 32'(req_ready), 32'(1) << (n % 4));
      tick();
      lat = 1;
      while (!out_valid && lat < 10) begin
        tick();
        lat++;
      end
      check($sformatf("rr id %0d", n), 32'(out_id), n % 4);
      check($sformatf("rr y %0d", n), 32'(out_y), 1);
      if (n == 4) req_valid = '0;
      tick();
      exp_count++;
    end
    check("rr count", 32'(op_count), exp_count);

    // Backpressure: XOR(1,0) on requester 1 held in DONE
    out_ready = 1'b0;
    req_a[1] = 1'b1;
    req_b[1] = 1'b0;
    req_op[5:3] = 3'd5;
    req_valid = 4'b0010;
    #1;
    check("bp accept", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    req_valid = 4'b1000;
    #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp valid %0d", i), 32'(out_valid), 1);
      check($sformatf("bp y %0d", i), 32'(out_y), 1);
      check($sformatf("bp id %0d", i), 32'(out_id), 1);
      check($sformatf("bp ready %0d", i), 32'(req_ready), 0);
      check($sformatf("bp count %0d", i), 32'(op_count), exp_count);
      tick();
    end
    out_ready = 1'b1;
    tick();
    exp_count++;
    check("bp count inc", 32'(op_count), exp_count);
    check("bp idle", 32'(busy), 0);
    check("bp ready r3", 32'(req_ready), 32'h8);
    req_valid = '0;
    #1;

    // Sparse: requester 2 valid only while busy, then re-asserted
    req_a[0] = 1'b0;
    req_b[0] = 1'b0;
    req_op[2:0] = 3'd4;
    req_valid = 4'b0001;
    #1;
    check("sp accept r0", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0100;
    tick();
    check("sp ready busy", 32'(req_ready), 0);
    req_valid = '0;
    lat = 2;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check("sp nor latency", lat, 3);
    check("sp nor y", 32'(out_y), 1);
    check("sp nor id", 32'(out_id), 0);
    tick();
    exp_count++;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      seen = seen | out_valid | busy | (|req_ready);
      tick();
    end
    check("sp no spurious", 32'(seen), 0);
    exp_count = exp_count % 16;
    run_op(2, 3'd2, 1'b1, 1'b0);

    // Counter wrap with CNTW=4
    do_reset();
    for (int i = 0; i < 16; i++) begin
      run_op(i % 4, 3'(i % 8), i[0], i[1]);
    end
    check("wrap zero", 32'(op_count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
